// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its queue controller.
package instr_register_pkg;

    typedef enum logic [3:0] {
        ZERO  = 4'd0,
        PASSA = 4'd1,
        PASSB = 4'd2,
        ADD   = 4'd3,
        SUB   = 4'd4,
        MULT  = 4'd5,
        DIV   = 4'd6,
        MOD   = 4'd7
    } opcode_t;

    typedef logic signed [31:0] operand_t;
    typedef logic [4:0]         address_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
    } instruction_t;

    localparam int DEPTH = 32;

    // Wide enough to hold 0..DEPTH inclusive.
    typedef logic [5:0] count_t;

    typedef enum logic [0:0] {
        RUN        = 1'b0,
        FLUSH_WAIT = 1'b1
    } ctrl_state_t;

    // Circular pointer advance; wraps 31 -> 0 through address_t width.
    function automatic address_t ptr_inc(input address_t p);
        return p + 5'd1;
    endfunction

endpackage

// File: rtl/instr_register_ctrl_rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting from the priority index.
module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IW-1:0] prio_r;
    logic [IW-1:0] next_prio_s;
    int            idx_s;

    // Scan from lowest priority to highest so the highest-priority requester wins last
    always_comb begin
        grant       = '0;
        next_prio_s = prio_r;
        idx_s       = 0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            idx_s = (int'(prio_r) + off) % NUM_REQ;
            if (req[idx_s]) begin
                grant       = NUM_REQ'(1'b1) << idx_s;
                next_prio_s = IW'((idx_s + 1) % NUM_REQ);
            end else begin
                grant       = grant;
                next_prio_s = next_prio_s;
            end
        end
    end

    // Priority moves past the winner only when the grant was actually taken
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio_r <= '0;
        end else if (advance) begin
            prio_r <= next_prio_s;
        end else begin
            prio_r <= prio_r;
        end
    end

endmodule

// File: rtl/instr_register_ctrl.sv
// FIFO controller and write arbiter in front of the 32-entry instruction register.
module instr_register_ctrl
    import instr_register_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] wr_valid,
    output logic [NUM_REQ-1:0] wr_ready,
    input  instruction_t       wr_instr [NUM_REQ],
    output logic               rd_valid,
    input  logic               rd_ready,
    output instruction_t       rd_instr,
    input  logic               flush,
    output logic               load_en,
    output address_t           write_pointer,
    output address_t           read_pointer,
    output opcode_t            opcode,
    output operand_t           operand_a,
    output operand_t           operand_b,
    input  instruction_t       instruction_word,
    output count_t             count,
    output logic               full,
    output logic               empty
);

    ctrl_state_t        state_r;
    ctrl_state_t        state_next_s;
    logic               in_run_s;
    logic               clear_s;
    logic [NUM_REQ-1:0] grant_s;
    logic               accept_s;
    logic               pop_s;
    instruction_t       win_instr_s;

    logic               load_en_r;
    address_t           wp_r;
    address_t           rp_r;
    count_t             count_r;
    opcode_t            opcode_r;
    operand_t           operand_a_r;
    operand_t           operand_b_r;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (wr_valid),
        .advance (accept_s),
        .grant   (grant_s)
    );

    // A write in flight (load_en) already owns a slot, so it counts against capacity.
    assign full     = ({1'b0, count_r} + {6'd0, load_en_r}) == 7'(DEPTH);
    assign empty    = (count_r == 6'd0);
    assign wr_ready = grant_s & {NUM_REQ{in_run_s & ~full}};
    assign accept_s = |wr_ready;
    assign rd_valid = in_run_s & ~empty;
    assign pop_s    = rd_valid & rd_ready;
    assign rd_instr = instruction_word;

    assign load_en       = load_en_r;
    assign write_pointer = wp_r;
    assign read_pointer  = rp_r;
    assign count         = count_r;
    assign opcode        = opcode_r;
    assign operand_a     = operand_a_r;
    assign operand_b     = operand_b_r;

    // Payload mux for the granted requester
    always_comb begin
        win_instr_s = wr_instr[0];
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_s[i]) begin
                win_instr_s = wr_instr[i];
            end else begin
                win_instr_s = win_instr_s;
            end
        end
    end

    // Controller state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= RUN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; a flush waits out any in-flight write before clearing
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            RUN: begin
                if (flush) state_next_s = FLUSH_WAIT;
                else       state_next_s = RUN;
            end
            FLUSH_WAIT: begin
                if (!load_en_r) state_next_s = RUN;
                else            state_next_s = FLUSH_WAIT;
            end
            default: state_next_s = RUN;
        endcase
    end

    // State-decoded controls
    always_comb begin
        in_run_s = 1'b0;
        clear_s  = 1'b0;
        case (state_r)
            RUN: begin
                in_run_s = 1'b1;
                clear_s  = 1'b0;
            end
            FLUSH_WAIT: begin
                in_run_s = 1'b0;
                clear_s  = ~load_en_r;
            end
            default: begin
                in_run_s = 1'b0;
                clear_s  = 1'b0;
            end
        endcase
    end

    // Write stage: enable and data presented to the register one cycle after accept
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_en_r   <= 1'b0;
            opcode_r    <= opcode_t'(4'd0);
            operand_a_r <= 32'sd0;
            operand_b_r <= 32'sd0;
        end else begin
            load_en_r <= accept_s;
            if (accept_s) begin
                opcode_r    <= win_instr_s.opc;
                operand_a_r <= win_instr_s.op_a;
                operand_b_r <= win_instr_s.op_b;
            end else begin
                opcode_r    <= opcode_r;
                operand_a_r <= operand_a_r;
                operand_b_r <= operand_b_r;
            end
        end
    end

    // Pointers and occupancy; occupancy, not pointer equality, decides full/empty
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp_r    <= 5'd0;
            rp_r    <= 5'd0;
            count_r <= 6'd0;
        end else if (clear_s) begin
            wp_r    <= wp_r;
            rp_r    <= wp_r;
            count_r <= 6'd0;
        end else begin
            wp_r <= load_en_r ? ptr_inc(wp_r) : wp_r;
            rp_r <= pop_s ? ptr_inc(rp_r) : rp_r;
            case ({load_en_r, pop_s})
                2'b10:   count_r <= count_r + 6'd1;
                2'b01:   count_r <= count_r - 6'd1;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_register_ctrl.sv
// Randomized scoreboard bench for instr_register_ctrl with a stand-in instruction register.
module tb_instr_register_ctrl;
    import instr_register_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   wr_valid;
    logic [1:0]   wr_ready;
    instruction_t wr_instr [2];
    logic         rd_valid;
    logic         rd_ready;
    instruction_t rd_instr;
    logic         flush;
    logic         load_en;
    address_t     write_pointer;
    address_t     read_pointer;
    opcode_t      opcode;
    operand_t     operand_a;
    operand_t     operand_b;
    instruction_t instruction_word;
    logic [5:0]   count;
    logic         full;
    logic         empty;

    instr_register_ctrl #(.NUM_REQ(2)) dut (
        .clk              (clk),
        .reset            (reset),
        .wr_valid         (wr_valid),
        .wr_ready         (wr_ready),
        .wr_instr         (wr_instr),
        .rd_valid         (rd_valid),
        .rd_ready         (rd_ready),
        .rd_instr         (rd_instr),
        .flush            (flush),
        .load_en          (load_en),
        .write_pointer    (write_pointer),
        .read_pointer     (read_pointer),
        .opcode           (opcode),
        .operand_a        (operand_a),
        .operand_b        (operand_b),
        .instruction_word (instruction_word),
        .count            (count),
        .full             (full),
        .empty            (empty)
    );

    always #5 clk = ~clk;

    // Stand-in for instr_register: synchronous write, combinational read.
    instruction_t mem [32];
    int           wcount = 0;
    always @(posedge clk) begin
        if (load_en) begin
            mem[write_pointer] <= {opcode, operand_a, operand_b};
            wcount             <= wcount + 1;
        end
    end
    assign instruction_word = mem[read_pointer];

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: committed entries in order, plus one in-flight write.
    instruction_t exp_q [$];
    bit           m_run = 1'b1;
    bit           m_pending = 1'b0;
    instruction_t m_pend;
    int           m_rr = 0;
    int           m_wp = 0;
    bit           d_acc = 1'b0;
    bit           d_flush = 1'b0;
    int           d_win = 0;
    instruction_t d_instr;
    instruction_t mon_exp;

    function automatic instruction_t rnd_instr();
        instruction_t t;
        t.opc  = opcode_t'(4'($urandom_range(0, 7)));
        t.op_a = $urandom;
        t.op_b = $urandom;
        return t;
    endfunction

    function automatic instruction_t mk(input int o, input int a, input int b);
        instruction_t t;
        t.opc  = opcode_t'(4'(o));
        t.op_a = a;
        t.op_b = b;
        return t;
    endfunction

    task automatic model_edge();
        if (m_pending) begin
            exp_q.push_back(m_pend);
            m_wp = (m_wp + 1) % 32;
        end
        if (!m_run && !m_pending) begin
            exp_q.delete();
            m_run = 1'b1;
        end else if (m_run && d_flush) begin
            m_run = 1'b0;
        end
        m_pending = d_acc;
        m_pend    = d_instr;
        if (d_acc) m_rr = (d_win + 1) % 2;
        d_acc   = 1'b0;
        d_flush = 1'b0;
    endtask

    task automatic check_cycle();
        int         qn;
        int         g;
        bit         exp_full;
        logic [1:0] exp_ready;
        qn        = exp_q.size();
        exp_full  = (qn + int'(m_pending)) == 32;
        g         = -1;
        if (wr_valid[m_rr])          g = m_rr;
        else if (wr_valid[1 - m_rr]) g = 1 - m_rr;
        exp_ready = 2'b00;
        if (m_run && !exp_full && g >= 0) exp_ready[g] = 1'b1;
        chk("wr_ready", wr_ready, exp_ready);
        chk("full", full, exp_full);
        chk("empty", empty, qn == 0);
        chk("count", count, qn);
        chk("rd_valid", rd_valid, m_run && qn != 0);
        chk("load_en", load_en, m_pending);
        chk("write_pointer", write_pointer, m_wp);
        chk("read_pointer", read_pointer, (m_wp - qn + 32) % 32);
        if (m_pending) chk("write_data", {opcode, operand_a, operand_b}, m_pend);
        d_acc   = (exp_ready != 2'b00);
        d_win   = g;
        d_instr = (g >= 0) ? wr_instr[g] : m_pend;
        d_flush = flush;
    endtask

    task automatic cycle(input logic [1:0] v, input instruction_t i0, input instruction_t i1,
                         input logic rdy, input logic fl);
        @(posedge clk);
        model_edge();
        #1;
        wr_valid    = v;
        wr_instr[0] = i0;
        wr_instr[1] = i1;
        rd_ready    = rdy;
        flush       = fl;
        #1;
        check_cycle();
    endtask

    task automatic idle(input logic rdy);
        cycle(2'b00, rnd_instr(), rnd_instr(), rdy, 1'b0);
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && (exp_q.size() != 0 || m_pending || !m_run); k++) idle(1'b1);
        if (exp_q.size() != 0 || m_pending || !m_run) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: %0d entries still expected", exp_q.size());
        end
    endtask

    task automatic check_reset_values();
        chk("rst_load_en", load_en, 1'b0);
        chk("rst_write_pointer", write_pointer, 5'd0);
        chk("rst_read_pointer", read_pointer, 5'd0);
        chk("rst_count", count, 6'd0);
        chk("rst_empty", empty, 1'b1);
        chk("rst_full", full, 1'b0);
        chk("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_opcode", opcode, 4'd0);
        chk("rst_operands", {operand_a, operand_b}, 64'd0);
    endtask

    // Monitor: every read handshake must deliver the oldest expected entry.
    always @(negedge clk) begin
        if (!reset && rd_valid && rd_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rd_underflow: got %0h expected no valid entry", rd_instr);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("rd_instr", rd_instr, mon_exp);
            end
        end
    end

    initial begin
        int wc;
        int waited;
        reset       = 1'b1;
        wr_valid    = 2'b00;
        rd_ready    = 1'b0;
        flush       = 1'b0;
        wr_instr[0] = '0;
        wr_instr[1] = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values();
        chk("rst_wr_ready", wr_ready, 2'b00);
        @(negedge clk);
        reset = 1'b0;

        // Single write of {1,5,7} from requester 0, then read it back.
        cycle(2'b01, mk(1, 5, 7), rnd_instr(), 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b1);
        drain();

        // Contention: grants alternate.
        repeat (4) cycle(2'b11, rnd_instr(), rnd_instr(), 1'b0, 1'b0);
        drain();

        // Fill to full, overflow attempt, one pop, then more writes.
        repeat (36) cycle(2'($urandom_range(1, 3)), rnd_instr(), rnd_instr(), 1'b0, 1'b0);
        cycle(2'b11, rnd_instr(), rnd_instr(), 1'b1, 1'b0);
        repeat (3) cycle(2'b10, rnd_instr(), rnd_instr(), 1'b0, 1'b0);
        drain();

        // Flush with a write in flight, and flush with an accept in the flush cycle.
        cycle(2'b01, rnd_instr(), rnd_instr(), 1'b0, 1'b0);
        cycle(2'b00, rnd_instr(), rnd_instr(), 1'b0, 1'b1);
        repeat (3) cycle(2'b11, rnd_instr(), rnd_instr(), 1'b1, 1'b1);
        repeat (3) idle(1'b0);
        drain();

        // Randomized traffic in phases of differing read pressure.
        for (int p = 0; p < 12; p++) begin
            int rd_pct;
            rd_pct = (p % 3 == 0) ? 10 : ((p % 3 == 1) ? 90 : 50);
            repeat (60) cycle(2'($urandom_range(0, 3)), rnd_instr(), rnd_instr(),
                              $urandom_range(0, 99) < rd_pct,
                              $urandom_range(0, 49) == 0);
        end

        // Asynchronous reset while a write is in flight.
        waited = 0;
        while (!m_pending && waited < 50) begin
            cycle(2'b01, rnd_instr(), rnd_instr(), 1'b0, 1'b0);
            waited++;
        end
        chk("reset_setup_pending", load_en, 1'b1);
        #1;
        wr_valid = 2'b00;
        rd_ready = 1'b0;
        reset    = 1'b1;
        #1;
        check_reset_values();
        wc = wcount;
        @(posedge clk);
        #1;
        chk("reset_no_write", wcount, wc);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        m_run     = 1'b1;
        m_pending = 1'b0;
        m_rr      = 0;
        m_wp      = 0;
        d_acc     = 1'b0;
        d_flush   = 1'b0;

        repeat (150) cycle(2'($urandom_range(0, 3)), rnd_instr(), rnd_instr(),
                           $urandom_range(0, 1) == 1, $urandom_range(0, 59) == 0);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
